eeg_epoch_sequencer: RTL

SoC-side stage that feeds the CiM accelerator over its SoC interface bundle. It buffers incoming ADC EEG samples in a small FIFO and opens each sleep epoch with the `new_sleep_epoch`/`start_eeg_load` pulse. It then streams exactly one epoch of samples as rate-limited `new_eeg_data` strobes, waits for `inference_complete`, and captures the inferred sleep stage for the SoC.

---
 rtl/eeg_epoch_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/eeg_epoch_sequencer.sv
// rtl/eeg_epoch_sequencer.sv - epoch framing and rate-limited EEG sample feed to the CiM accelerator
module eeg_epoch_sequencer #(
    parameter int SAMPLES_PER_EPOCH = 3000,
    parameter int FIFO_DEPTH        = 16,
    parameter int SAMPLE_GAP        = 2,
    parameter int ADC_W             = 16,
    parameter int STAGE_W           = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               epoch_tick,
    input  logic               adc_valid,
    input  logic [ADC_W-1:0]   adc_data,
    output logic               new_sleep_epoch,
    output logic               start_eeg_load,
    output logic               new_eeg_data,
    output logic [ADC_W-1:0]   eeg,
    input  logic               inference_complete,
    input  logic [STAGE_W-1:0] inferred_sleep_stage,
    output logic               stage_valid,
    output logic [STAGE_W-1:0] stage,
    output logic               busy,
    output logic               overflow,
    output logic               epoch_overrun
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SAMPLES_PER_EPOCH + 1);
    localparam int GAP_W = (SAMPLE_GAP > 0) ? $clog2(SAMPLE_GAP + 1) : 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_EPOCH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP);

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_INF} state_t;

    state_t             state;
    logic [ADC_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   count;
    logic [GAP_W-1:0]   gap;

    logic fifo_empty;
    logic fifo_full;
    logic issue;
    logic last_issue;
    logic push_window;
    logic push;
    logic drop;

    assign fifo_empty  = (occ == '0);
    assign fifo_full   = (occ == OCC_FULL);
    assign issue       = (state == STREAM) && !fifo_empty && (gap == '0);
    // The final issue of an epoch flushes the FIFO, so a sample arriving on that edge is discarded.
    assign last_issue  = issue && (count == CNT_LAST);
    assign push_window = (state == START) || ((state == STREAM) && !last_issue);
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push        = push_window && adc_valid && (!fifo_full || issue);
    assign drop        = push_window && adc_valid && fifo_full && !issue;
    assign busy        = (state != IDLE);

    // Sample storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= adc_data;
        end
    end

    // Epoch sequencing FSM with FIFO bookkeeping, issue pacing and registered CiM-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            count           <= '0;
            gap             <= '0;
            new_sleep_epoch <= 1'b0;
            start_eeg_load  <= 1'b0;
            new_eeg_data    <= 1'b0;
            eeg             <= '0;
            stage_valid     <= 1'b0;
            stage           <= '0;
            overflow        <= 1'b0;
            epoch_overrun   <= 1'b0;
        end else begin
            new_sleep_epoch <= 1'b0;
            start_eeg_load  <= 1'b0;
            new_eeg_data    <= 1'b0;
            stage_valid     <= 1'b0;

            if (epoch_tick && (state != IDLE)) begin
                epoch_overrun <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                eeg          <= mem[rd_ptr];
                new_eeg_data <= 1'b1;
                count        <= count + CNT_W'(1);
                gap          <= GAP_LOAD;
            end else if ((state == STREAM) && (gap != '0)) begin
                gap <= gap - GAP_W'(1);
            end
            if (push && !issue) begin
                occ <= occ + OCC_W'(1);
            end else if (issue && !push) begin
                occ <= occ - OCC_W'(1);
            end

            // Flushes below are placed last so they override the push/pop updates above.
            case (state)
                IDLE: begin
                    if (epoch_tick) begin
                        state           <= START;
                        overflow        <= 1'b0;
                        epoch_overrun   <= 1'b0;
                        count           <= '0;
                        gap             <= '0;
                        wr_ptr          <= '0;
                        rd_ptr          <= '0;
                        occ             <= '0;
                        new_sleep_epoch <= 1'b1;
                        start_eeg_load  <= 1'b1;
                    end
                end
                START: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (last_issue) begin
                        state  <= WAIT_INF;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        occ    <= '0;
                    end
                end
                WAIT_INF: begin
                    if (inference_complete) begin
                        stage       <= inferred_sleep_stage;
                        stage_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
